custom_axi_proc_core: RTL and testbench
=======================================

# custom_axi_proc_core

Parametrised, multi-channel successor to the single-channel custom AXI processing core. It accepts data words over a valid/ready input stream into a small FIFO and processes each word with a selectable operation: pass, add-step, or per-channel accumulate. Each result is delivered on a valid/ready output stream, with state and error reporting. It sits behind the AXI register slice, which drives the input stream and configuration, and reads back results and status.

## Interface
Parameters:
- DATA_WIDTH, 16, width of data, step and accumulators
- NUM_CH, 4, number of channels/accumulators (≥1); CH_W = max(1, $clog2(NUM_CH))
- FIFO_DEPTH, 4, input FIFO entries (power of two, ≥2)

Ports:
- clk_i  in  1  single clock, all logic rising-edge
- rst_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  FIFO can accept (not full and rst_i low)
- in_data_i  in  DATA_WIDTH  input word
- in_ch_i  in  CH_W  channel tag
- in_mode_i  in  2  0 pass, 1 add-step, 2 accumulate, 3 reserved (error)
- step_i  in  DATA_WIDTH  step for mode 1, quasi-static, sampled in BUSY
- clear_i  in  1  zero all accumulators
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts
- out_data_o  out  DATA_WIDTH  result
- out_ch_o  out  CH_W  result channel tag
- status_o  out  2  current state: 0 IDLE, 1 BUSY, 2 DONE, 3 ERROR
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- err_count_o  out  8  saturating error count

## Operation
- Reset (rst_i high at an edge): FIFO emptied; state IDLE; all accumulators 0; out_valid_o 0; out_data_o 0; out_ch_o 0; status_o 0; fifo_level_o 0; err_count_o 0. in_ready_o is 0 while rst_i is high.
- Push: in_valid_i && in_ready_o at an edge stores {in_ch_i, in_mode_i, in_data_i}.
- FIFO is full at FIFO_DEPTH entries. A push and a pop at the same edge leave the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head into the work register and go to BUSY. Otherwise stay.
  - BUSY: if mode == 3 or ch ≥ NUM_CH, go to ERROR. Otherwise compute the result, register it into out_data_o/out_ch_o, and go to DONE.
  - Mode 0: result = data.
  - Mode 1: result = (data + step_i) mod 2^DATA_WIDTH.
  - Mode 2: result = (acc[ch] + data) mod 2^DATA_WIDTH, and acc[ch] ← result.
  - DONE: out_valid_o = 1 with stable data/ch. On out_ready_i, go to IDLE. Otherwise hold.
  - ERROR: for one cycle, err_count_o += 1 (saturates at 255), no output; then go to IDLE.
- clear_i: all accumulators ← 0 at that edge. It takes priority over a same-edge mode-2 update. The output of that update still carries the pre-clear sum.
- The input FIFO keeps accepting while the FSM is in BUSY, DONE or ERROR.
- status_o is the registered state encoding.

## Timing
- Word pushed at edge 0 into an empty FIFO with FSM in IDLE:
  - fifo_level_o = 1 after edge 0.
  - Popped at edge 1; status BUSY.
  - Result registered at edge 2; out_valid_o high after edge 2.
- Output handshake completes at the first edge where out_valid_o && out_ready_i. out_valid_o drops after that edge.
- Peak throughput is one word per 3 cycles (IDLE→BUSY→DONE) with out_ready_i held high.
- An errored word occupies 3 cycles (IDLE, BUSY, ERROR) and produces no output.
- Reset mid-operation: the pending output and FIFO contents are discarded. out_valid_o is 0 after the reset edge.

## Test plan
- Reset, then push mode 0, data 0x1234, ch 1, with out_ready_i high → out_valid_o after edge 2 with out_data_o 0x1234, out_ch_o 1; status_o sequence 0,1,2,0.
- Mode 1, step 0x0002, data 0xFFFF → out_data_o 0x0001 (wrap). Mode 2 on ch 2 with data 5 then 7 → outputs 5 then 12. Then clear_i, then data 3 → output 3.
- Hold out_ready_i low and push 5 words → in_ready_o low when fifo_level_o = 4. The fifth word is accepted once the first is popped. Output 0x1234 is held stable until ready.
- Mode 3, then ch = NUM_CH (with NUM_CH = 3 so the tag is representable) → status_o 3 for one cycle each, err_count_o 2, no out_valid_o. 256 errors → err_count_o stays 255.
- rst_i asserted while in DONE with 3 words queued → after the edge: out_valid_o 0, fifo_level_o 0, status_o 0, accumulators 0.

Source files
------------

// File: rtl/custom_axi_proc_core.sv
// Multi-channel stream processing core: input FIFO, pass / add-step / accumulate
// operations, valid/ready result output, state and saturating error reporting.
module custom_axi_proc_core #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [CH_W-1:0]       in_ch_i,
    input  logic [1:0]            in_mode_i,
    input  logic [DATA_WIDTH-1:0] step_i,
    input  logic                  clear_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [CH_W-1:0]       out_ch_o,
    output logic [1:0]            status_o,
    output logic [LVL_W-1:0]      fifo_level_o,
    output logic [7:0]            err_count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = CH_W + 2 + DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;

    logic [ENT_W-1:0]        fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [LVL_W-1:0]        level_r;
    logic                    full_s;
    logic                    push_s;
    logic                    pop_s;

    logic [DATA_WIDTH-1:0]   work_data_r;
    logic [CH_W-1:0]         work_ch_r;
    logic [1:0]              work_mode_r;
    logic                    work_err_s;

    logic [DATA_WIDTH-1:0]   acc_r [NUM_CH];
    logic [DATA_WIDTH-1:0]   acc_sel_s;
    logic [DATA_WIDTH-1:0]   result_s;

    logic                    out_valid_r;
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic [CH_W-1:0]         out_ch_r;
    logic [7:0]              err_count_r;

    assign full_s     = (level_r == LVL_W'(FIFO_DEPTH));
    assign in_ready_o = !full_s && !rst_i;
    assign push_s     = in_valid_i && in_ready_o;
    assign pop_s      = (state_r == ST_IDLE) && (level_r != {LVL_W{1'b0}});

    // FIFO storage; contents need no reset since the level gates every read
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {in_ch_i, in_mode_i, in_data_i};
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Work register holds the word being processed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            work_data_r <= {DATA_WIDTH{1'b0}};
            work_ch_r   <= {CH_W{1'b0}};
            work_mode_r <= 2'd0;
        end else if (pop_s) begin
            {work_ch_r, work_mode_r, work_data_r} <= fifo_mem_r[rd_ptr_r];
        end else begin
            work_data_r <= work_data_r;
            work_ch_r   <= work_ch_r;
            work_mode_r <= work_mode_r;
        end
    end

    assign work_err_s = (work_mode_r == 2'd3) ||
                        ({1'b0, work_ch_r} >= (CH_W + 1)'(NUM_CH));

    // Accumulator select by OR-reduction so an out-of-range tag reads zero
    always_comb begin
        acc_sel_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            acc_sel_s = acc_sel_s | (acc_r[i] & {DATA_WIDTH{work_ch_r == CH_W'(i)}});
        end
    end

    // Operation datapath
    always_comb begin
        result_s = work_data_r;
        case (work_mode_r)
            2'd0:    result_s = work_data_r;
            2'd1:    result_s = work_data_r + step_i;
            2'd2:    result_s = acc_sel_s + work_data_r;
            default: result_s = work_data_r;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (work_err_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_ERROR: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Result register; data and tag stay stable while waiting for the consumer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_ch_r    <= {CH_W{1'b0}};
        end else begin
            case (state_r)
                ST_BUSY: begin
                    if (!work_err_s) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= result_s;
                        out_ch_r    <= work_ch_r;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_r <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    // Accumulators; a clear wins over a same-edge update (the output keeps the sum)
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst_i || clear_i) begin
                acc_r[i] <= {DATA_WIDTH{1'b0}};
            end else if ((state_r == ST_BUSY) && !work_err_s && (work_mode_r == 2'd2) &&
                         (work_ch_r == CH_W'(i))) begin
                acc_r[i] <= result_s;
            end else begin
                acc_r[i] <= acc_r[i];
            end
        end
    end

    // Saturating error counter, bumped on the cycle spent in ERROR
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_count_r <= 8'd0;
        end else if ((state_r == ST_ERROR) && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'd1;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign out_valid_o  = out_valid_r;
    assign out_data_o   = out_data_r;
    assign out_ch_o     = out_ch_r;
    assign status_o     = state_r;
    assign fifo_level_o = level_r;
    assign err_count_o  = err_count_r;

endmodule

// File: tb/tb_custom_axi_proc_core.sv
// Scoreboard bench for custom_axi_proc_core (NUM_CH = 3 so tag 3 is an invalid channel).
module tb_custom_axi_proc_core;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic [1:0]  in_ch = 2'd0;
    logic [1:0]  in_mode = 2'd0;
    logic [15:0] step = 16'h0;
    logic        clear = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [1:0]  out_ch;
    logic [1:0]  status;
    logic [2:0]  fifo_level;
    logic [7:0]  err_count;

    custom_axi_proc_core #(.DATA_WIDTH(16), .NUM_CH(3), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .in_ch_i(in_ch), .in_mode_i(in_mode), .step_i(step), .clear_i(clear),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_ch_o(out_ch), .status_o(status), .fifo_level_o(fifo_level),
        .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [17:0] exp_q [$];
    int unsigned model_acc [3];
    int unsigned model_err = 0;
    bit rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: results follow FIFO order, so they can be computed at acceptance
    function automatic void model_word(input int unsigned d, input int unsigned ch, input int unsigned md);
        int unsigned r;
        if (md == 3 || ch >= 3) begin
            if (model_err < 255) model_err++;
        end else begin
            if (md == 0) r = d;
            else if (md == 1) r = (d + step) % 65536;
            else begin
                r = (model_acc[ch] + d) % 65536;
                model_acc[ch] = r;
            end
            exp_q.push_back({ch[1:0], r[15:0]});
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_word(input logic [15:0] d, input logic [1:0] ch, input logic [1:0] md);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_ch = ch; in_mode = md;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("push_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        model_word(d, ch, md);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        forever begin
            tick();
            if (fifo_level == 3'd0 && status == 2'd0 && !out_valid) break;
            n++;
            if (n > 2000) begin
                chk("drain_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) model_acc[i] = 0;
    endtask

    // Monitor: a handshake completes at the next rising edge when valid && ready here
    always @(negedge clk) begin
        if (!rst_i && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {14'd0, out_ch, out_data}, 32'hFFFFFFFF);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                chk("out_ch_data", {14'd0, out_ch, out_data}, {14'd0, e});
            end
        end
    end

    initial begin
        int cnt;
        for (int i = 0; i < 3; i++) model_acc[i] = 0;

        // Reset state
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_status", {30'd0, status}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_err", {24'd0, err_count}, 32'd0);
        rst_i = 1'b0;
        tick();
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // First-word latency and status sequence
        push_word(16'h1234, 2'd1, 2'd0);
        chk("lat_level", {29'd0, fifo_level}, 32'd1);
        chk("lat_status0", {30'd0, status}, 32'd0);
        tick();
        chk("lat_status1", {30'd0, status}, 32'd1);
        tick();
        chk("lat_status2", {30'd0, status}, 32'd2);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_data", {16'd0, out_data}, 32'h1234);
        tick();
        chk("lat_status3", {30'd0, status}, 32'd0);
        chk("lat_valid_drop", {31'd0, out_valid}, 32'd0);

        // Step wrap, accumulate, clear
        step = 16'h0002;
        push_word(16'hFFFF, 2'd0, 2'd1);
        push_word(16'd5, 2'd2, 2'd2);
        push_word(16'd7, 2'd2, 2'd2);
        wait_idle();
        pulse_clear();
        push_word(16'd3, 2'd2, 2'd2);
        wait_idle();

        // Backpressure: FIFO fills and the held output stays stable
        out_ready = 1'b0;
        push_word(16'h1234, 2'd0, 2'd0);
        for (int i = 0; i < 4; i++) push_word(16'(16'h100 + i), 2'd1, 2'd0);
        chk("full_level", {29'd0, fifo_level}, 32'd4);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_data", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h1234});
        end
        out_ready = 1'b1;
        push_word(16'h0BEE, 2'd2, 2'd0);
        wait_idle();

        // Errors: reserved mode, then out-of-range channel
        push_word(16'h0001, 2'd0, 2'd3);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (status == 2'd3) cnt++;
        end
        chk("err_mode_cycles", cnt, 32'd1);
        push_word(16'h0002, 2'd3, 2'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (status == 2'd3) cnt++;
        end
        chk("err_ch_cycles", cnt, 32'd1);
        chk("err_count_2", {24'd0, err_count}, model_err);

        // Randomized batches
        for (int b = 0; b < 6; b++) begin
            wait_idle();
            step = 16'($urandom);
            if ($urandom_range(0, 1) == 1) pulse_clear();
            rnd_ready = 1'b1;
            for (int w = 0; w < 30; w++) begin
                push_word(16'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
                if ($urandom_range(0, 3) == 0) tick();
            end
            wait_idle();
            chk("rand_err_count", {24'd0, err_count}, model_err);
        end

        // Error counter saturation
        for (int i = 0; i < 260; i++) push_word(16'(i), 2'd0, 2'd3);
        wait_idle();
        chk("err_saturate", {24'd0, err_count}, model_err);

        // Reset in DONE with three words queued
        push_word(16'd40, 2'd1, 2'd2);
        wait_idle();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(16'(16'h200 + i), 2'd0, 2'd0);
        chk("pre_rst_status", {30'd0, status}, 32'd2);
        chk("pre_rst_level", {29'd0, fifo_level}, 32'd3);
        rst_i = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_level", {29'd0, fifo_level}, 32'd0);
        chk("mid_rst_status", {30'd0, status}, 32'd0);
        rst_i = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) model_acc[i] = 0;
        model_err = 0;
        out_ready = 1'b1;
        chk("mid_rst_err", {24'd0, err_count}, model_err);
        push_word(16'd9, 2'd1, 2'd2);
        wait_idle();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
